// File: rtl/mem_fill_writer_pkg.sv
// Shared types for the memory fill writer.
package mem_fill_writer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fill_state_t;

endpackage

// File: rtl/mem_fill_writer_if.sv
// Stream input and memory write port of the fill writer.
// master: the writer itself; slave: the stream source and memory side.
interface mem_fill_writer_if #(
  parameter int addrbits = 4,
  parameter int width    = 8
);
  logic                in_valid;
  logic                in_ready;
  logic [width-1:0]    in_data;
  logic                write_clk;
  logic                write_en;
  logic [addrbits-1:0] write_addr;
  logic [width-1:0]    write_data;

  modport master (
    input  in_valid, in_data,
    output in_ready, write_clk, write_en, write_addr, write_data
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, write_clk, write_en, write_addr, write_data
  );
endinterface

// File: rtl/mem_fill_addr_gen.sv
// Address / remaining-count generator with modulo-depth wrap.
module mem_fill_addr_gen #(
  parameter int depth    = 16,
  parameter int addrbits = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                load,
  input  logic [addrbits-1:0] load_addr,
  input  logic [addrbits:0]   load_len,
  input  logic                step,
  output logic [addrbits-1:0] addr,
  output logic [addrbits:0]   remaining,
  output logic                last
);

  localparam logic [addrbits:0]   DEPTH_L   = (addrbits+1)'(depth);
  localparam logic [addrbits-1:0] LAST_ADDR = addrbits'(depth - 1);

  assign last = (remaining == (addrbits+1)'(1));

  // Load reduces the address modulo depth and saturates the length; step advances.
  always_ff @(posedge clock) begin
    if (reset) begin
      addr      <= '0;
      remaining <= '0;
    end else if (load) begin
      addr      <= addrbits'(32'(load_addr) % depth);
      remaining <= (load_len > DEPTH_L) ? DEPTH_L : load_len;
    end else if (step) begin
      addr      <= (addr == LAST_ADDR) ? '0 : addr + 1'b1;
      remaining <= remaining - 1'b1;
    end
  end

endmodule

// File: rtl/mem_fill_writer.sv
// Sequences a memory write port over a wrapping address range, sourcing
// words from a valid/ready stream or from a constant fill value.
module mem_fill_writer
  import mem_fill_writer_pkg::*;
#(
  parameter int depth       = 16,
  parameter int addrbits    = 4,
  parameter int width       = 8,
  parameter int isPipelined = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [addrbits-1:0] start_addr,
  input  logic [addrbits:0]   start_len,
  input  logic                fill_mode,
  input  logic [width-1:0]    fill_value,
  mem_fill_writer_if.master   wport,
  output logic                busy,
  output logic                done
);

  fill_state_t         state, state_nxt;
  logic                fill_r;
  logic [width-1:0]    fval_r;
  logic                zero_done_q;
  logic                accept;
  logic                beat;
  logic                last_beat;
  logic                ready;
  logic [width-1:0]    beat_data;
  logic [addrbits-1:0] cur_addr;
  logic [addrbits:0]   remaining;
  logic                last;

  assign wport.write_clk = clock;
  assign wport.in_ready  = ready;

  assign accept    = start && (state == ST_IDLE) && !busy;
  assign last_beat = beat && last;
  assign beat_data = fill_r ? fval_r : wport.in_data;

  mem_fill_addr_gen #(
    .depth    (depth),
    .addrbits (addrbits)
  ) u_addr_gen (
    .clock     (clock),
    .reset     (reset),
    .load      (accept),
    .load_addr (start_addr),
    .load_len  (start_len),
    .step      (beat),
    .addr      (cur_addr),
    .remaining (remaining),
    .last      (last)
  );

  // State register plus burst configuration latched at start.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      fill_r      <= 1'b0;
      fval_r      <= '0;
      zero_done_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      zero_done_q <= accept && (start_len == '0);
      if (accept) begin
        fill_r <= fill_mode;
        fval_r <= fill_value;
      end
    end
  end

  // Next state, stream handshake and beat qualification.
  always_comb begin
    state_nxt = state;
    beat      = 1'b0;
    ready     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept && (start_len != '0)) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        ready = !fill_r;
        beat  = fill_r || wport.in_valid;
        if (beat && last) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  generate
    if (isPipelined != 0) begin : g_piped
      logic                wen_q;
      logic                done_q;
      logic [addrbits-1:0] waddr_q;
      logic [width-1:0]    wdata_q;

      // Register the accepted beat; addr/data hold between beats.
      always_ff @(posedge clock) begin
        if (reset) begin
          wen_q   <= 1'b0;
          done_q  <= 1'b0;
          waddr_q <= '0;
          wdata_q <= '0;
        end else begin
          wen_q  <= beat;
          done_q <= last_beat;
          if (beat) begin
            waddr_q <= cur_addr;
            wdata_q <= beat_data;
          end
        end
      end

      assign wport.write_en   = wen_q;
      assign wport.write_addr = waddr_q;
      assign wport.write_data = wdata_q;
      assign done             = done_q || zero_done_q;
      // The final write lands after the FSM is back in IDLE, so busy covers it.
      assign busy             = (state == ST_RUN) || done_q;
    end else begin : g_comb
      logic [addrbits-1:0] addr_hold;
      logic [width-1:0]    data_hold;

      // Remember the last written word so addr/data hold when no beat occurs.
      always_ff @(posedge clock) begin
        if (reset) begin
          addr_hold <= '0;
          data_hold <= '0;
        end else if (beat) begin
          addr_hold <= cur_addr;
          data_hold <= beat_data;
        end
      end

      assign wport.write_en   = beat;
      assign wport.write_addr = beat ? cur_addr : addr_hold;
      assign wport.write_data = beat ? beat_data : data_hold;
      assign done             = last_beat || zero_done_q;
      assign busy             = (state == ST_RUN);
    end
  endgenerate

endmodule

// File: tb/tb_mem_fill_writer.sv
// Self-checking bench for mem_fill_writer (depth 16, pipelined write port).
module tb_mem_fill_writer;

  localparam int DEPTH = 16;
  localparam int AB    = 4;
  localparam int W     = 8;

  logic          clk;
  logic          reset;
  logic          start;
  logic [AB-1:0] start_addr;
  logic [AB:0]   start_len;
  logic          fill_mode;
  logic [W-1:0]  fill_value;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  mem_fill_writer_if #(.addrbits(AB), .width(W)) tif ();

  mem_fill_writer #(
    .depth       (DEPTH),
    .addrbits    (AB),
    .width       (W),
    .isPipelined (1)
  ) dut (
    .clock      (clk),
    .reset      (reset),
    .start      (start),
    .start_addr (start_addr),
    .start_len  (start_len),
    .fill_mode  (fill_mode),
    .fill_value (fill_value),
    .wport      (tif.master),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Burst-level view: an active burst has a current address, words left and
  // a source; each accepted word appears on the write port one cycle later.
  bit          m_active;
  bit          m_fill;
  int          m_fval;
  int          m_addr;
  int          m_left;
  bit          exp_wen, exp_done, exp_busy, exp_ready;
  int          exp_addr, exp_data;
  bit          cmp_en = 0;

  always @(posedge clk) begin
    bit take;
    bit take_last;
    int wa, wd, len;
    cmp_en <= 1;
    if (reset) begin
      m_active = 0; m_fill = 0; m_fval = 0; m_addr = 0; m_left = 0;
      exp_wen = 0; exp_done = 0; exp_busy = 0; exp_ready = 0;
      exp_addr = 0; exp_data = 0;
    end else begin
      take      = m_active && (m_fill || tif.in_valid === 1'b1);
      take_last = take && (m_left == 1);
      wa = m_addr;
      wd = m_fill ? m_fval : int'(tif.in_data);
      if (take) begin
        m_addr = (m_addr + 1) % DEPTH;
        m_left = m_left - 1;
        if (m_left == 0) m_active = 0;
      end
      exp_done = 0;
      if (start && !exp_busy && !exp_ready && !(m_active || take)) begin
        len = (int'(start_len) > DEPTH) ? DEPTH : int'(start_len);
        if (len == 0) exp_done = 1;
        else begin
          m_active = 1;
          m_fill   = fill_mode;
          m_fval   = int'(fill_value);
          m_addr   = int'(start_addr) % DEPTH;
          m_left   = len;
        end
      end
      exp_wen = take;
      if (take) begin
        exp_addr = wa;
        exp_data = wd;
      end
      if (take_last) exp_done = 1;
      exp_busy  = m_active || take_last;
      exp_ready = m_active && !m_fill;
    end
  end

  // Per-cycle comparison and write log.
  logic [AB+W-1:0] wlog[$];
  int              done_cnt = 0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("write_en", 32'(tif.write_en), 32'(exp_wen));
      check("done", 32'(done), 32'(exp_done));
      check("busy", 32'(busy), 32'(exp_busy));
      check("in_ready", 32'(tif.in_ready), 32'(exp_ready));
      check("write_addr", 32'(tif.write_addr), 32'(exp_addr));
      check("write_data", 32'(tif.write_data), 32'(exp_data));
      check("write_clk", 32'(tif.write_clk), 32'(clk));
      if (tif.write_en === 1'b1) wlog.push_back({tif.write_addr, tif.write_data});
      if (done === 1'b1) done_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start(input int a, input int l, input bit f, input int v);
    start      = 1'b1;
    start_addr = AB'(a);
    start_len  = (AB+1)'(l);
    fill_mode  = f;
    fill_value = W'(v);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic clear_log();
    wlog.delete();
    done_cnt = 0;
  endtask

  task automatic check_entry(input string name, input int idx, input int a, input int d);
    logic [AB+W-1:0] e;
    e = (idx < wlog.size()) ? wlog[idx] : '1;
    check(name, 32'(e), 32'({AB'(a), W'(d)}));
  endtask

  logic [W-1:0] sdata [6];
  bit           svalid[6];

  initial begin
    reset = 1'b1; start = 1'b1; start_addr = 4'd2; start_len = 5'd3;
    fill_mode = 1'b0; fill_value = '0;
    tif.in_valid = 1'b1; tif.in_data = 8'hFF;

    // 1: reset held with start and in_valid asserted
    cycles(4);
    check("rst_write_en", 32'(tif.write_en), 0);
    check("rst_in_ready", 32'(tif.in_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_write_addr", 32'(tif.write_addr), 0);
    start = 1'b0; tif.in_valid = 1'b0; reset = 1'b0;
    cycles(2);
    check("post_rst_writes", wlog.size(), 0);

    // 2: stream burst with gaps in in_valid
    clear_log();
    svalid = '{1, 0, 1, 1, 0, 1};
    sdata  = '{8'hA1, 8'hA1, 8'hA2, 8'hA3, 8'hA3, 8'hA4};
    do_start(3, 4, 0, 0);
    for (int i = 0; i < 6; i++) begin
      tif.in_valid = svalid[i];
      tif.in_data  = sdata[i];
      @(negedge clk);
    end
    tif.in_valid = 1'b0;
    check("t2_done_last", 32'(done), 1);
    check("t2_busy_last", 32'(busy), 1);
    cycles(1);
    check("t2_busy_after", 32'(busy), 0);
    cycles(2);
    check("t2_count", wlog.size(), 4);
    check_entry("t2_w0", 0, 3, 'hA1);
    check_entry("t2_w1", 1, 4, 'hA2);
    check_entry("t2_w2", 2, 5, 'hA3);
    check_entry("t2_w3", 3, 6, 'hA4);
    check("t2_done_cnt", done_cnt, 1);

    // 3: fill with wrap, stray in_valid must not matter
    clear_log();
    tif.in_valid = 1'b1; tif.in_data = 8'h11;
    do_start(14, 4, 1, 'h5A);
    cycles(7);
    tif.in_valid = 1'b0;
    check("t3_count", wlog.size(), 4);
    check_entry("t3_w0", 0, 14, 'h5A);
    check_entry("t3_w1", 1, 15, 'h5A);
    check_entry("t3_w2", 2, 0, 'h5A);
    check_entry("t3_w3", 3, 1, 'h5A);
    check("t3_done_cnt", done_cnt, 1);

    // 4: zero length, then saturating length
    clear_log();
    do_start(0, 0, 1, 'h77);
    check("t4_zero_done", 32'(done), 1);
    check("t4_zero_busy", 32'(busy), 0);
    cycles(3);
    check("t4_zero_count", wlog.size(), 0);
    check("t4_zero_done_cnt", done_cnt, 1);
    clear_log();
    do_start(5, 20, 1, 'h3C);
    cycles(22);
    check("t4_sat_count", wlog.size(), 16);
    check_entry("t4_sat_first", 0, 5, 'h3C);
    check_entry("t4_sat_wrap", 11, 0, 'h3C);
    check_entry("t4_sat_last", 15, 4, 'h3C);
    check("t4_sat_done_cnt", done_cnt, 1);

    // 5: start while busy is ignored
    clear_log();
    do_start(2, 8, 1, 'h33);
    cycles(3);
    do_start(9, 2, 0, 'hEE);
    cycles(10);
    check("t5_count", wlog.size(), 8);
    for (int i = 0; i < 8; i++) check_entry("t5_w", i, (2 + i) % DEPTH, 'h33);
    check("t5_done_cnt", done_cnt, 1);

    // 6: reset after the second of five stream beats
    clear_log();
    do_start(0, 5, 0, 0);
    tif.in_valid = 1'b1; tif.in_data = 8'hB1;
    @(negedge clk);
    tif.in_data = 8'hB2;
    @(negedge clk);
    reset = 1'b1; tif.in_data = 8'hB3;
    @(negedge clk);
    check("t6_rst_wen", 32'(tif.write_en), 0);
    check("t6_rst_done", 32'(done), 0);
    cycles(1);
    reset = 1'b0; tif.in_valid = 1'b0;
    cycles(4);
    check("t6_count", wlog.size(), 2);
    check_entry("t6_w0", 0, 0, 'hB1);
    check_entry("t6_w1", 1, 1, 'hB2);
    check("t6_done_cnt", done_cnt, 0);
    clear_log();
    do_start(7, 1, 0, 0);
    tif.in_valid = 1'b1; tif.in_data = 8'hC3;
    @(negedge clk);
    tif.in_valid = 1'b0;
    cycles(3);
    check("t6_new_count", wlog.size(), 1);
    check_entry("t6_new_w0", 0, 7, 'hC3);
    check("t6_new_done_cnt", done_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
